// File: rtl/mlbmp_plot.sv
// mlbmp_plot: host-side single-pixel plotter for the monochrome bitmap VRAM.
// Each command does a read-modify-write of the VRAM byte holding the pixel.
// Byte layout: addr = {y, x>>3}, pixel x[2:0]=0 sits in bit 7.
// Optional feature: define MLBMP_PLOT_CACHE_EN to keep a one-byte write-through
// cache, so a repeated access to the same byte skips the VRAM read.
module mlbmp_plot #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [1:0]  cmd_op,
  output logic        rd_valid,
  output logic        rd_pixel,
  output logic        err,
  output logic        vram_req,
  input  logic        vram_gnt,
  output logic [15:0] vram_addr,
  output logic        vram_rd_en,
  input  logic [7:0]  vram_rdata,
  output logic        vram_wr_en,
  output logic [7:0]  vram_wdata
);

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_TOG = 2'b10;
  localparam logic [1:0] OP_QRY = 2'b11;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, REQ, RD, WAIT, WR} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [2:0]         bit_q;
  logic [7:0]         byte_q;
  logic [CNT_W-1:0]   lat_cnt;
  logic               accept;
  logic               in_range;
  logic               last_wait;
  logic               cache_hit;
  logic [7:0]         hit_byte;
  logic [7:0]         wdata_mod;

  // Apply the pixel operation to one byte; x[2:0]=0 maps to the MSB.
  function automatic logic [7:0] modify_byte(input logic [7:0] b,
                                             input logic [1:0] op,
                                             input logic [2:0] xb);
    logic [7:0] mask;
    mask = 8'h80 >> xb;
    case (op)
      OP_CLR:  return b & ~mask;
      OP_SET:  return b | mask;
      OP_TOG:  return b ^ mask;
      default: return b;
    endcase
  endfunction

  // Extract the addressed pixel from a byte.
  function automatic logic pick_pixel(input logic [7:0] b, input logic [2:0] xb);
    return b[3'd7 - xb];
  endfunction

  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = (32'(cmd_x) < WIDTH) && (32'(cmd_y) < HEIGHT);
  assign last_wait = (state == WAIT) && (lat_cnt == CNT_W'(RD_LATENCY - 1));
  assign wdata_mod = modify_byte(byte_q, op_q, bit_q);

`ifdef MLBMP_PLOT_CACHE_EN
  logic [15:0] cache_addr;
  logic [7:0]  cache_data;
  logic        cache_vld;

  assign cache_hit = cache_vld && (cache_addr == vram_addr);
  assign hit_byte  = cache_data;

  // Write-through cache: refreshed by every read capture and every write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld <= 1'b0;
    end else if (last_wait) begin
      cache_vld  <= 1'b1;
      cache_addr <= vram_addr;
      cache_data <= vram_rdata;
    end else if (state == WR) begin
      cache_data <= wdata_mod;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_byte  = 8'h00;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and VRAM strobes.
  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    vram_req   = 1'b0;
    vram_rd_en = 1'b0;
    vram_wr_en = 1'b0;
    vram_wdata = 8'h00;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept && in_range) state_nxt = REQ;
      end
      REQ: begin
        vram_req = 1'b1;
        if (vram_gnt) begin
          if (cache_hit) state_nxt = (op_q == OP_QRY) ? IDLE : WR;
          else           state_nxt = RD;
        end
      end
      RD: begin
        vram_req   = 1'b1;
        vram_rd_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        vram_req = 1'b1;
        if (last_wait) state_nxt = (op_q == OP_QRY) ? IDLE : WR;
      end
      WR: begin
        vram_req   = 1'b1;
        vram_wr_en = 1'b1;
        vram_wdata = wdata_mod;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command address, error pulse and query result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_addr <= 16'h0000;
      rd_valid  <= 1'b0;
      rd_pixel  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err      <= accept && !in_range;
      rd_valid <= 1'b0;
      if (accept && in_range) vram_addr <= {cmd_y, 8'(cmd_x[8:3])};
      if (state == REQ && vram_gnt && cache_hit && op_q == OP_QRY) begin
        rd_valid <= 1'b1;
        rd_pixel <= pick_pixel(hit_byte, bit_q);
      end
      if (last_wait && op_q == OP_QRY) begin
        rd_valid <= 1'b1;
        rd_pixel <= pick_pixel(vram_rdata, bit_q);
      end
    end
  end

  // Command fields, read-latency counter and the byte being modified.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= cmd_op;
      bit_q <= cmd_x[2:0];
    end
    if (state == RD)        lat_cnt <= '0;
    else if (state == WAIT) lat_cnt <= lat_cnt + 1'b1;
    if (last_wait)
      byte_q <= vram_rdata;
    else if (state == REQ && vram_gnt && cache_hit)
      byte_q <= hit_byte;
  end

endmodule

// File: tb/tb_mlbmp_plot.sv
// Bench for mlbmp_plot: a table of pixel commands against a VRAM model
// (RD_LATENCY=1 instance) plus hand-written grant, latency, reset and cache
// sequences. A second instance runs with RD_LATENCY=3.
module tb_mlbmp_plot;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_TOG = 2'b10;
  localparam logic [1:0] OP_QRY = 2'b11;
`ifdef MLBMP_PLOT_CACHE_EN
  localparam int EXP_HIT_RD = 0;
`else
  localparam int EXP_HIT_RD = 1;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [1:0]  op;
    logic [7:0]  pre;
    logic        exp_err;
    logic [15:0] addr;
    logic [7:0]  val;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [1:0]  cmd_op;
  logic        rd_valid, rd_pixel, err;
  logic        vram_req, vram_gnt;
  logic [15:0] vram_addr;
  logic        vram_rd_en, vram_wr_en;
  logic [7:0]  vram_rdata, vram_wdata;

  logic        c3_valid, c3_ready;
  logic [8:0]  c3_x;
  logic [7:0]  c3_y;
  logic [1:0]  c3_op;
  logic        c3_rd_valid, c3_rd_pixel, c3_err;
  logic        c3_req, c3_gnt;
  logic [15:0] c3_addr;
  logic        c3_rd_en, c3_wr_en;
  logic [7:0]  c3_rdata, c3_wdata;

  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  wr_t  wq[$];
  logic qq[$];
  vec_t tbl [13];

  logic [7:0]  mem [65536];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic        rv1;
  logic [7:0]  rd1;
  logic [2:0]  v3 = 3'b000;

  mlbmp_plot #(.WIDTH(320), .HEIGHT(240), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_op(cmd_op), .rd_valid(rd_valid),
    .rd_pixel(rd_pixel), .err(err), .vram_req(vram_req), .vram_gnt(vram_gnt),
    .vram_addr(vram_addr), .vram_rd_en(vram_rd_en), .vram_rdata(vram_rdata),
    .vram_wr_en(vram_wr_en), .vram_wdata(vram_wdata)
  );

  mlbmp_plot #(.WIDTH(320), .HEIGHT(240), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_x(c3_x), .cmd_y(c3_y), .cmd_op(c3_op), .rd_valid(c3_rd_valid),
    .rd_pixel(c3_rd_pixel), .err(c3_err), .vram_req(c3_req), .vram_gnt(c3_gnt),
    .vram_addr(c3_addr), .vram_rd_en(c3_rd_en), .vram_rdata(c3_rdata),
    .vram_wr_en(c3_wr_en), .vram_wdata(c3_wdata)
  );

  // VRAM model, read latency 1; rdata is junk (A5) except in the valid cycle.
  always @(posedge clk) begin
    if (pl_en)           mem[pl_addr]   <= pl_data;
    else if (vram_wr_en) mem[vram_addr] <= vram_wdata;
    rv1 <= vram_rd_en;
    rd1 <= mem[vram_addr];
  end
  assign vram_rdata = rv1 ? rd1 : 8'hA5;

  // Latency-3 VRAM model: every byte reads as 3C, valid only 3 cycles after rd_en.
  always @(posedge clk) v3 <= {v3[1:0], c3_rd_en};
  assign c3_rdata = v3[2] ? 8'h3C : 8'hA5;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any DUT write / query result.
  task automatic tick();
    wr_t  w;
    logic p;
    @(negedge clk);
    if (!rst) begin
      if (vram_rd_en) rd_cnt++;
      if (vram_wr_en) begin
        check("wr_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          check("wr_addr", 32'(vram_addr), 32'(w.addr));
          check("wr_data", 32'(vram_wdata), 32'(w.data));
        end
      end
      if (rd_valid) begin
        check("rdv_expected", 32'(qq.size() > 0), 32'd1);
        if (qq.size() > 0) begin
          p = qq.pop_front();
          check("rd_pixel", 32'(rd_pixel), 32'(p));
        end
      end
    end
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("idle_reached", 32'(cmd_ready), 32'd1);
  endtask

  // Present one command; returns at the falling edge of the cycle after acceptance.
  task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [1:0] op);
    wait_idle();
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_op = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int r0;
    vec_t v;
    tbl[0]  = '{9'd17,  8'd2,   OP_SET, 8'h00, 1'b0, 16'h0202, 8'h40};
    tbl[1]  = '{9'd10,  8'd2,   OP_SET, 8'h0F, 1'b0, 16'h0201, 8'h2F};
    tbl[2]  = '{9'd13,  8'd2,   OP_SET, 8'h2F, 1'b0, 16'h0201, 8'h2F};
    tbl[3]  = '{9'd13,  8'd2,   OP_TOG, 8'h2F, 1'b0, 16'h0201, 8'h2B};
    tbl[4]  = '{9'd13,  8'd2,   OP_TOG, 8'h2B, 1'b0, 16'h0201, 8'h2F};
    tbl[5]  = '{9'd13,  8'd2,   OP_QRY, 8'h2F, 1'b0, 16'h0201, 8'h01};
    tbl[6]  = '{9'd319, 8'd239, OP_CLR, 8'hFF, 1'b0, 16'hEF27, 8'hFE};
    tbl[7]  = '{9'd319, 8'd239, OP_QRY, 8'hFE, 1'b0, 16'hEF27, 8'h00};
    tbl[8]  = '{9'd319, 8'd239, OP_SET, 8'hFE, 1'b0, 16'hEF27, 8'hFF};
    tbl[9]  = '{9'd320, 8'd0,   OP_SET, 8'h00, 1'b1, 16'h0000, 8'h00};
    tbl[10] = '{9'd0,   8'd240, OP_SET, 8'h00, 1'b1, 16'h0000, 8'h00};
    tbl[11] = '{9'd511, 8'd255, OP_TOG, 8'h00, 1'b1, 16'h0000, 8'h00};
    tbl[12] = '{9'd7,   8'd0,   OP_CLR, 8'hFF, 1'b0, 16'h0000, 8'hFE};

    rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_op = '0;
    vram_gnt = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    c3_valid = 1'b0; c3_x = '0; c3_y = '0; c3_op = '0; c3_gnt = 1'b1;
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_req",       32'(vram_req), 32'd0);
    check("rst_rd_en",     32'(vram_rd_en), 32'd0);
    check("rst_wr_en",     32'(vram_wr_en), 32'd0);
    check("rst_addr",      32'(vram_addr), 32'd0);
    check("rst_wdata",     32'(vram_wdata), 32'd0);
    check("rst_rd_valid",  32'(rd_valid), 32'd0);
    check("rst_rd_pixel",  32'(rd_pixel), 32'd0);
    check("rst_err",       32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Set (0,0): cycle-by-cycle timing of one full read-modify-write.
    preload(16'h0000, 8'h00);
    exp_wr(16'h0000, 8'h80);
    send(9'd0, 8'd0, OP_SET);
    check("t1_ready", 32'(cmd_ready), 32'd0);
    check("t1_req",   32'(vram_req), 32'd1);
    check("t1_rd_en", 32'(vram_rd_en), 32'd0);
    tick();
    check("t2_ready", 32'(cmd_ready), 32'd0);
    check("t2_rd_en", 32'(vram_rd_en), 32'd1);
    check("t2_addr",  32'(vram_addr), 32'h0000);
    tick();
    check("t3_ready", 32'(cmd_ready), 32'd0);
    check("t3_rd_wr", 32'({vram_rd_en, vram_wr_en}), 32'd0);
    tick();
    check("t4_ready", 32'(cmd_ready), 32'd0);
    check("t4_wr_en", 32'(vram_wr_en), 32'd1);
    tick();
    check("t5_ready", 32'(cmd_ready), 32'd1);
    check("t5_req",   32'(vram_req), 32'd0);
    check("t5_wq_drained", 32'(wq.size()), 32'd0);

    // Table of commands.
    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      if (v.exp_err) begin
        send(v.x, v.y, v.op);
        check("err_pulse",   32'(err), 32'd1);
        check("err_no_req",  32'(vram_req), 32'd0);
        check("err_ready",   32'(cmd_ready), 32'd1);
        tick();
        check("err_one_cyc", 32'(err), 32'd0);
        check("err_no_req2", 32'(vram_req), 32'd0);
      end else begin
        preload(v.addr, v.pre);
        if (v.op == OP_QRY) qq.push_back(v.val[0]);
        else                exp_wr(v.addr, v.val);
        send(v.x, v.y, v.op);
        wait_idle();
        if (v.op == OP_QRY) begin
          tick();
          check("rdv_one_cyc", 32'(rd_valid), 32'd0);
        end
        check("tbl_wq_drained", 32'(wq.size()), 32'd0);
        check("tbl_qq_drained", 32'(qq.size()), 32'd0);
      end
    end

    // Grant withheld for 6 cycles: no read until the grant arrives.
    vram_gnt = 1'b0;
    preload(16'h0A05, 8'h01);
    exp_wr(16'h0A05, 8'h81);
    send(9'd40, 8'd10, OP_SET);
    for (int k = 0; k < 6; k++) begin
      check("nognt_rd_en", 32'(vram_rd_en), 32'd0);
      check("nognt_req",   32'(vram_req), 32'd1);
      tick();
    end
    vram_gnt = 1'b1;
    tick();
    check("gnt_rd_en", 32'(vram_rd_en), 32'd1);
    check("gnt_addr",  32'(vram_addr), 32'h0A05);
    wait_idle();
    check("gnt_wq_drained", 32'(wq.size()), 32'd0);

    // RD_LATENCY=3 instance: capture exactly 3 cycles after rd_en.
    c3_valid = 1'b1; c3_x = 9'd1; c3_y = 8'd1; c3_op = OP_SET;
    tick();
    c3_valid = 1'b0;
    check("l3_ready_low", 32'(c3_ready), 32'd0);
    tick();
    check("l3_rd_en", 32'(c3_rd_en), 32'd1);
    check("l3_addr",  32'(c3_addr), 32'h0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("l3_wait_no_wr", 32'({c3_rd_en, c3_wr_en}), 32'd0);
    end
    tick();
    check("l3_wr_en",  32'(c3_wr_en), 32'd1);
    check("l3_wdata",  32'(c3_wdata), 32'h7C);
    check("l3_waddr",  32'(c3_addr), 32'h0100);
    tick();
    check("l3_ready", 32'(c3_ready), 32'd1);

    // Reset during WAIT on the latency-3 instance: command lost, no write.
    c3_valid = 1'b1; c3_x = 9'd2; c3_y = 8'd1; c3_op = OP_CLR;
    tick();
    c3_valid = 1'b0;
    tick();
    check("rw_rd_en", 32'(c3_rd_en), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("rw_ready", 32'(c3_ready), 32'd1);
    check("rw_strobes", 32'({c3_req, c3_rd_en, c3_wr_en, c3_rd_valid, c3_err}), 32'd0);
    check("rw_addr",  32'(c3_addr), 32'd0);
    check("rw_wdata", 32'(c3_wdata), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rw_no_wr", 32'({c3_wr_en, c3_req}), 32'd0);
    end

    // Same-byte repeat: cache build skips the read; reset forces a read again.
    pulse_rst();
    preload(16'h0001, 8'h00);
    exp_wr(16'h0001, 8'h80);
    r0 = rd_cnt;
    send(9'd8, 8'd0, OP_SET);
    wait_idle();
    check("c_first_rd", 32'(rd_cnt - r0), 32'd1);
    exp_wr(16'h0001, 8'hC0);
    r0 = rd_cnt;
    send(9'd9, 8'd0, OP_SET);
    wait_idle();
    check("c_repeat_rd", 32'(rd_cnt - r0), 32'(EXP_HIT_RD));
    pulse_rst();
    exp_wr(16'h0001, 8'hC0);
    r0 = rd_cnt;
    send(9'd9, 8'd0, OP_SET);
    wait_idle();
    check("c_after_rst_rd", 32'(rd_cnt - r0), 32'd1);

    tick(); tick();
    check("final_wq_drained", 32'(wq.size()), 32'd0);
    check("final_qq_drained", 32'(qq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
